// File: rtl/capture_sequencer_pkg.sv
// Shared types and widths for the capture sequencer: FSM encoding, geometry
// and frame-count widths, plus a small geometry validity helper.
package capture_sequencer_pkg;

  localparam int GEOM_W    = 12;
  localparam int NFRAMES_W = 16;
  localparam int COUNT_W   = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARM,
    ST_WAIT_ACK,
    ST_CAPTURE,
    ST_NEXT,
    ST_ABORT
  } state_e;

  // A start is only accepted when both dimensions are non-zero.
  function automatic logic geom_valid(input logic [GEOM_W-1:0] w,
                                      input logic [GEOM_W-1:0] h);
    return (w != '0) && (h != '0);
  endfunction

endpackage

// File: rtl/capture_sequencer_timeout.sv
// Per-state watchdog: counts cycles while enabled and flags expiry once the
// state has lasted LIMIT cycles. Clear restarts the count on state entry.
module seq_timeout_counter #(
  parameter logic [31:0] LIMIT = 32'd50_000_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [31:0] count_q, count_d;

  assign expired = enable && (count_q == LIMIT - 32'd1);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 32'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of process ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/capture_sequencer.sv
// Sequences a frame-capture block: loads geometry via a reset pulse, arms each
// frame, watches the frame-complete flag and aborts on stop or timeout.
module capture_sequencer
  import capture_sequencer_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000,
  parameter int unsigned LOAD_CYCLES    = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [GEOM_W-1:0]    cfg_width,
  input  logic [GEOM_W-1:0]    cfg_height,
  input  logic                 cmd_start,
  input  logic                 cmd_stop,
  input  logic [NFRAMES_W-1:0] cmd_nframes,
  output logic                 cap_reset_n,
  output logic                 cap_start,
  output logic [GEOM_W-1:0]    cap_width,
  output logic [GEOM_W-1:0]    cap_height,
  input  logic                 cap_captured,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic                 cfg_err,
  output logic [COUNT_W-1:0]   frame_count
);

  state_e               state_q, state_d;
  logic [31:0]          load_cnt_q, load_cnt_d;
  logic [NFRAMES_W-1:0] remaining_q, remaining_d;
  logic                 continuous_q, continuous_d;
  logic [GEOM_W-1:0]    cap_width_q, cap_width_d;
  logic [GEOM_W-1:0]    cap_height_q, cap_height_d;
  logic [COUNT_W-1:0]   frame_count_q, frame_count_d;
  logic                 cap_reset_n_q, cap_reset_n_d;
  logic                 cap_start_q, cap_start_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;
  logic                 cfg_err_q, cfg_err_d;

  logic tmo_clear, tmo_enable, tmo_expired;

  seq_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  assign tmo_enable = (state_q == ST_WAIT_ACK) || (state_q == ST_CAPTURE);
  assign tmo_clear  = (state_d != state_q);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    load_cnt_d    = load_cnt_q;
    remaining_d   = remaining_q;
    continuous_d  = continuous_q;
    cap_width_d   = cap_width_q;
    cap_height_d  = cap_height_q;
    frame_count_d = frame_count_q;
    done_d        = 1'b0;
    timeout_d     = 1'b0;
    cfg_err_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Start together with stop is treated as no command at all.
        if (cmd_start && !cmd_stop) begin
          if (geom_valid(cfg_width, cfg_height)) begin
            cap_width_d  = cfg_width;
            cap_height_d = cfg_height;
            remaining_d  = cmd_nframes;
            continuous_d = (cmd_nframes == '0);
            load_cnt_d   = '0;
            state_d      = ST_LOAD;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (load_cnt_q >= LOAD_CYCLES - 32'd1) begin
          state_d = ST_ARM;
        end else begin
          load_cnt_d = load_cnt_q + 32'd1;
        end
      end
      ST_ARM: begin
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (!cap_captured) begin
          state_d = ST_CAPTURE;
        end else if (tmo_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_ABORT;
        end
      end
      ST_CAPTURE: begin
        if (cap_captured) begin
          state_d = ST_NEXT;
        end else if (tmo_expired) begin
          timeout_d = 1'b1;
          state_d   = ST_ABORT;
        end
      end
      ST_NEXT: begin
        frame_count_d = frame_count_q + 32'd1;
        if (continuous_q) begin
          state_d = ST_ARM;
        end else begin
          remaining_d = remaining_q - 1'b1;
          if (remaining_d != '0) begin
            state_d = ST_ARM;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_ABORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Stop overrides whatever the active state decided, including a frame
    // completing in this very cycle, so nothing is counted or pulsed.
    if (cmd_stop && (state_q != ST_IDLE)) begin
      state_d       = ST_ABORT;
      frame_count_d = frame_count_q;
      remaining_d   = remaining_q;
      done_d        = 1'b0;
      timeout_d     = 1'b0;
    end

    // Outputs are decoded from the next state so the registered copies line
    // up with the state register.
    cap_reset_n_d = !((state_d == ST_LOAD) || (state_d == ST_ABORT));
    cap_start_d   = (state_d == ST_ARM);
    busy_d        = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      load_cnt_q    <= '0;
      remaining_q   <= '0;
      continuous_q  <= 1'b0;
      cap_width_q   <= '0;
      cap_height_q  <= '0;
      frame_count_q <= '0;
      cap_reset_n_q <= 1'b0;
      cap_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_cnt_q    <= load_cnt_d;
      remaining_q   <= remaining_d;
      continuous_q  <= continuous_d;
      cap_width_q   <= cap_width_d;
      cap_height_q  <= cap_height_d;
      frame_count_q <= frame_count_d;
      cap_reset_n_q <= cap_reset_n_d;
      cap_start_q   <= cap_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign cap_reset_n = cap_reset_n_q;
  assign cap_start   = cap_start_q;
  assign cap_width   = cap_width_q;
  assign cap_height  = cap_height_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cfg_err     = cfg_err_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench for capture_sequencer: IDLE command table, then directed
// multi-frame, timeout, stop and mid-sequence reset sequences.
module tb_capture_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] cfg_width = '0;
  logic [11:0] cfg_height = '0;
  logic        cmd_start = 1'b0;
  logic        cmd_stop = 1'b0;
  logic [15:0] cmd_nframes = '0;
  logic        cap_reset_n, cap_start, busy, done, timeout, cfg_err;
  logic [11:0] cap_width, cap_height;
  logic [31:0] frame_count;
  logic        cap_captured;

  int tests = 0;
  int failed = 0;

  // Capture-block stand-in: after a cap_start, the flag drops for a few
  // cycles then rises again. Manual mode lets sequences drive it directly.
  logic       model_en = 1'b1;
  logic       man_cap = 1'b1;
  logic       model_cap;
  logic [4:0] mcnt;

  assign cap_captured = model_en ? model_cap : man_cap;

  always #5 clock = ~clock;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcnt      <= '0;
      model_cap <= 1'b1;
    end else begin
      if (cap_start) mcnt <= 5'd1;
      else if (mcnt != 0) mcnt <= (mcnt == 5'd10) ? 5'd0 : mcnt + 5'd1;
      model_cap <= !(mcnt >= 5'd2 && mcnt <= 5'd8);
    end
  end

  int n_start = 0, n_done = 0, n_tmo = 0, n_cfg = 0;
  always @(posedge clock) begin
    if (cap_start) n_start <= n_start + 1;
    if (done)      n_done  <= n_done + 1;
    if (timeout)   n_tmo   <= n_tmo + 1;
    if (cfg_err)   n_cfg   <= n_cfg + 1;
  end

  capture_sequencer #(
    .TIMEOUT_CYCLES (32'd100),
    .LOAD_CYCLES    (2)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .cfg_width    (cfg_width),
    .cfg_height   (cfg_height),
    .cmd_start    (cmd_start),
    .cmd_stop     (cmd_stop),
    .cmd_nframes  (cmd_nframes),
    .cap_reset_n  (cap_reset_n),
    .cap_start    (cap_start),
    .cap_width    (cap_width),
    .cap_height   (cap_height),
    .cap_captured (cap_captured),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout),
    .cfg_err      (cfg_err),
    .frame_count  (frame_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        start;
    logic        stop;
    logic [11:0] w;
    logic [11:0] h;
    logic        exp_busy;
    logic        exp_cfg_err;
  } vec_t;

  vec_t vecs[6];

  int s0, d0, t0, c0, k;
  logic seen;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 12'd0,   12'd480, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 12'd640, 12'd480, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 12'd640, 12'd0,   1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 12'd640, 12'd480, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 12'd640, 12'd480, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 12'd0,   12'd0,   1'b0, 1'b1};

    // Reset state
    #12;
    check("rst_cap_reset_n", cap_reset_n, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_cap_width", cap_width, 0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    check("idle_cap_reset_n", cap_reset_n, 1);
    check("idle_cap_start", cap_start, 0);

    // IDLE command table: rejected geometry and ignored start+stop
    s0 = n_start;
    for (int i = 0; i < 6; i++) begin
      cmd_start  = vecs[i].start;
      cmd_stop   = vecs[i].stop;
      cfg_width  = vecs[i].w;
      cfg_height = vecs[i].h;
      tick();
      check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      check($sformatf("vec%0d_cfg_err", i), cfg_err, vecs[i].exp_cfg_err);
      check($sformatf("vec%0d_cap_reset_n", i), cap_reset_n, 1);
    end
    cmd_start = 0; cmd_stop = 0;
    tick();
    check("cfg_err_no_cap_start", n_start - s0, 0);

    // Three-frame sequence, with a second start while busy
    s0 = n_start; d0 = n_done;
    cfg_width = 12'd640; cfg_height = 12'd480; cmd_nframes = 16'd3; cmd_start = 1;
    tick();
    check("load_busy", busy, 1);
    check("load_cap_reset_n", cap_reset_n, 0);
    cfg_width = 12'd123; cfg_height = 12'd77; cmd_nframes = 16'd1;
    tick();
    check("load2_cap_reset_n", cap_reset_n, 0);
    check("load2_cap_start", cap_start, 0);
    cmd_start = 0;
    tick();
    check("arm_cap_start", cap_start, 1);
    check("arm_cap_reset_n", cap_reset_n, 1);
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      if (done) seen = 1;
    end
    check("seq3_done_seen", seen, 1);
    tick();
    check("seq3_starts", n_start - s0, 3);
    check("seq3_frame_count", frame_count, 3);
    check("seq3_done_pulses", n_done - d0, 1);
    check("seq3_cap_width", cap_width, 640);
    check("seq3_cap_height", cap_height, 480);
    check("seq3_busy", busy, 0);

    // Timeout in WAIT_ACK with the flag stuck high
    model_en = 0; man_cap = 1;
    d0 = n_done; t0 = n_tmo;
    cfg_width = 12'd320; cfg_height = 12'd240; cmd_nframes = 16'd1; cmd_start = 1;
    tick();
    cmd_start = 0;
    k = 1; seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      k++;
      if (timeout) seen = 1;
    end
    check("tmo_seen", seen, 1);
    check("tmo_latency", k, 104);
    check("tmo_cap_reset_n", cap_reset_n, 0);
    tick();
    check("tmo_after_cap_reset_n", cap_reset_n, 1);
    check("tmo_after_busy", busy, 0);
    check("tmo_after_pulse", timeout, 0);
    check("tmo_frame_count", frame_count, 3);
    check("tmo_pulses", n_tmo - t0, 1);
    check("tmo_no_done", n_done - d0, 0);

    // Continuous run stopped after five more frames
    model_en = 1;
    d0 = n_done;
    cfg_width = 12'd640; cfg_height = 12'd480; cmd_nframes = 16'd0; cmd_start = 1;
    tick();
    cmd_start = 0;
    seen = 0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      tick();
      if (frame_count == 32'd8) seen = 1;
    end
    check("cont_reached_8", seen, 1);
    cmd_stop = 1;
    tick();
    check("cont_stop_cap_reset_n", cap_reset_n, 0);
    cmd_stop = 0;
    tick();
    check("cont_busy", busy, 0);
    check("cont_frame_count", frame_count, 8);
    check("cont_no_done", n_done - d0, 0);

    // Stop in the same cycle the frame completes: not counted
    model_en = 0; man_cap = 1;
    cmd_start = 1;
    tick();
    cmd_start = 0;
    repeat (3) tick();
    man_cap = 0;
    repeat (3) tick();
    man_cap = 1; cmd_stop = 1;
    tick();
    check("race_cap_reset_n", cap_reset_n, 0);
    cmd_stop = 0;
    tick();
    check("race_busy", busy, 0);
    check("race_frame_count", frame_count, 8);
    check("race_no_done", n_done - d0, 0);

    // Reset while in CAPTURE
    cmd_nframes = 16'd2; cmd_start = 1;
    tick();
    cmd_start = 0;
    repeat (3) tick();
    man_cap = 0;
    repeat (2) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("mrst_cap_reset_n", cap_reset_n, 0);
    check("mrst_busy", busy, 0);
    check("mrst_cap_start", cap_start, 0);
    check("mrst_frame_count", frame_count, 0);
    check("mrst_cap_width", cap_width, 0);
    man_cap = 1;
    s0 = n_start; d0 = n_done; t0 = n_tmo;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) tick();
    check("mrst_after_busy", busy, 0);
    check("mrst_after_cap_reset_n", cap_reset_n, 1);
    check("mrst_no_start", n_start - s0, 0);
    check("mrst_no_done", n_done - d0, 0);
    check("mrst_no_timeout", n_tmo - t0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/capture_sequencer.md
CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 32'd50_000_000, cycles allowed for each of WAIT_ACK and CAPTURE before abort (1 s at 50 MHz).
REQ-002 SHALL have parameter LOAD_CYCLES, default 2, width of the cap_reset_n low pulse used to load geometry.
REQ-003 SHALL use one clock and asynchronous active-low reset: clock  in  1  system clock; reset_n  in  1  async active-low reset.
REQ-004 SHALL have cfg_width  in  12  image width; cfg_height  in  12  image height (sampled only at accepted start).
REQ-005 SHALL have cmd_start  in  1  start pulse; cmd_stop  in  1  abort pulse; cmd_nframes  in  16  frames to capture, 0 = continuous.
REQ-006 SHALL have cap_reset_n  out  1  capture block reset; cap_start  out  1  capture start pulse; cap_width, cap_height  out  12  latched geometry; cap_captured  in  1  capture-block frame-complete flag (1 when idle).
REQ-007 SHALL have busy  out  1  sequence active; done  out  1  one-cycle end-of-sequence pulse; timeout  out  1  one-cycle abort-by-timeout pulse; cfg_err  out  1  one-cycle rejected-start pulse; frame_count  out  32  frames completed since reset.

Function
REQ-008 SHALL implement FSM states IDLE, LOAD, ARM, WAIT_ACK, CAPTURE, NEXT, ABORT.
REQ-009 IDLE: cmd_start=1 with cfg_width!=0 and cfg_height!=0 SHALL latch cap_width/cap_height and cmd_nframes, go to LOAD next cycle; busy=1 from that cycle.
REQ-010 IDLE: cmd_start=1 with cfg_width==0 or cfg_height==0 SHALL pulse cfg_err for one cycle and remain in IDLE.
REQ-011 LOAD SHALL drive cap_reset_n=0 for exactly LOAD_CYCLES cycles, then go to ARM.
REQ-012 ARM SHALL drive cap_start=1 for exactly one cycle, then go to WAIT_ACK.
REQ-013 WAIT_ACK SHALL go to CAPTURE on the first cycle cap_captured==0.
REQ-014 CAPTURE SHALL go to NEXT on the first cycle cap_captured==1.
REQ-015 NEXT SHALL increment frame_count (wraps 2^32-1 -> 0) and decrement the remaining count; if continuous or remaining!=0 go to ARM, else pulse done and go to IDLE.
REQ-016 Timeout counter SHALL clear on entry to WAIT_ACK and CAPTURE; reaching TIMEOUT_CYCLES SHALL pulse timeout and go to ABORT.
REQ-017 cmd_stop in any state other than IDLE SHALL go to ABORT next cycle; cmd_stop has priority over every other transition in that cycle, including completion in CAPTURE.
REQ-018 ABORT SHALL drive cap_reset_n=0 for one cycle, then go to IDLE without pulsing done; a frame aborted before NEXT SHALL NOT be counted.
REQ-019 cmd_start outside IDLE SHALL be ignored; cmd_start and cmd_stop together in IDLE SHALL be ignored.
REQ-020 cap_reset_n SHALL be 1 in every state except LOAD and ABORT; cap_start SHALL be 0 outside ARM.
REQ-021 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-022 On reset_n=0: state IDLE; cap_reset_n=0 (held low while in reset); cap_start=0; cap_width=cap_height=0; busy=done=timeout=cfg_err=0; frame_count=0; timeout and remaining counters 0.
REQ-023 Reset asserted mid-sequence SHALL abandon the sequence with no done or timeout pulse after release.

Structure
REQ-024 A shared package SHALL hold the state encoding, the 12-bit geometry width and the 16-bit frame-count width.
REQ-025 The timeout counter SHALL be one sub-module, seq_timeout_counter (clear, enable, expired).

Verification
REQ-026 Start with width=640, height=480, nframes=3; model captured drop/rise -> three cap_start pulses, frame_count=3, one done pulse, cap_width=640.
REQ-027 Start with width=0 -> cfg_err pulse, busy stays 0, no cap_start pulse.
REQ-028 TIMEOUT_CYCLES=100, captured held at 1 after ARM -> timeout pulse 100 cycles after WAIT_ACK entry, cap_reset_n low one cycle, IDLE, frame_count unchanged.
REQ-029 nframes=0, stop after 5 frames -> frame_count=5, no done pulse, IDLE; stop in the same cycle as captured rises -> frame_count stays 5.
REQ-030 Reset asserted while in CAPTURE -> all outputs at reset values within the same cycle; after release, no pulses and busy=0.
REQ-031 cmd_start asserted again while busy -> ignored; the configuration latched for the running sequence is unchanged.
